// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit: op encoding,
// CSR addresses, cause codes and mstatus field positions.
package csr_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_CSRRW = 3'd1,
      OP_CSRRS = 3'd2,
      OP_CSRRC = 3'd3,
      OP_ECALL = 3'd4,
      OP_MRET  = 3'd5
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam int unsigned CAUSE_ECALL_M = 32'd11;
   localparam int unsigned CAUSE_IRQ_MTI = 32'd7;

   localparam int unsigned MSTATUS_MIE    = 32'd3;
   localparam int unsigned MSTATUS_MPIE   = 32'd7;
   localparam int unsigned MSTATUS_MPP_LO = 32'd11;
   localparam int unsigned MSTATUS_MPP_HI = 32'd12;
   localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;

   localparam int unsigned MIE_MTIE = 32'd7;

   function automatic logic csr_is_read_only(input logic [11:0] addr);
      return (addr == CSR_MIP) || (addr == CSR_MVENDORID) || (addr == CSR_MARCHID);
   endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running cycle counter; a write to either half replaces that
// cycle's increment and freezes the other half.
module csr_counter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_lo_i,
   input  logic [31:0] wdata_hi_i,
   output logic [63:0] count_o
);

   logic [63:0] cnt_q;
   logic [63:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 64'd1;
      if (wr_lo_i || wr_hi_i) begin
         cnt_d = cnt_q;
         if (wr_lo_i) begin
            cnt_d[31:0] = wdata_lo_i;
         end else begin
            cnt_d[31:0] = cnt_q[31:0];
         end
         if (wr_hi_i) begin
            cnt_d[63:32] = wdata_hi_i;
         end else begin
            cnt_d[63:32] = cnt_q[63:32];
         end
      end else begin
         cnt_d = cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 64'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Handshaked machine-mode CSR file with ECALL/MRET trap stacking and
// timer-interrupt entry at request boundaries; one response per request.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int HAS_COUNTERS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic                  req_wr_en,
   input  logic [11:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [ADDR_WIDTH-1:0] req_pc,
   input  logic                  irq_timer,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_illegal,
   output logic                  rsp_redirect,
   output logic [ADDR_WIDTH-1:0] rsp_target
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;
   localparam logic [DATA_WIDTH-1:0] EPC_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDR_WIDTH-1:0] TGT_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   logic [0:0]            state_q, state_d;
   logic                  mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
   logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_illegal_q, rsp_illegal_d;
   logic                  rsp_redirect_q, rsp_redirect_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0] rsp_target_q, rsp_target_d;

   csr_op_e               op_s;
   logic [DATA_WIDTH-1:0] csr_rdata_s, wval_s;
   logic                  csr_exists_s, is_csr_s, wr_s, illegal_s, accept_s, irq_take_s;
   logic                  cyc_wr_lo_s, cyc_wr_hi_s;
   logic [63:0]           cycle_s;
   logic [ADDR_WIDTH-1:0] trap_tgt_s;

   assign op_s       = csr_op_e'(req_op);
   assign accept_s   = req_valid && (state_q == S_IDLE);
   assign irq_take_s = irq_timer && mie_q && mtie_q;
   assign is_csr_s   = (op_s == OP_CSRRW) || (op_s == OP_CSRRS) || (op_s == OP_CSRRC);
   assign wr_s       = (op_s == OP_CSRRW) || (is_csr_s && req_wr_en);
   assign illegal_s  = is_csr_s && (!csr_exists_s || (csr_is_read_only(req_addr) && wr_s));
   assign trap_tgt_s = ADDR_WIDTH'(mtvec_q) & TGT_MASK;

   // CSR read mux; also decides whether the address exists in this build
   always_comb begin
      csr_rdata_s  = '0;
      csr_exists_s = 1'b1;
      case (req_addr)
         CSR_MSTATUS: begin
            csr_rdata_s = DATA_WIDTH'(MSTATUS_RST);
            csr_rdata_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            csr_rdata_s[MSTATUS_MIE]  = mie_q;
            csr_rdata_s[MSTATUS_MPIE] = mpie_q;
         end
         CSR_MIE:       csr_rdata_s[MIE_MTIE] = mtie_q;
         CSR_MTVEC:     csr_rdata_s = mtvec_q;
         CSR_MEPC:      csr_rdata_s = mepc_q;
         CSR_MCAUSE:    csr_rdata_s = mcause_q;
         CSR_MIP:       csr_rdata_s[MIE_MTIE] = irq_timer;
         CSR_MVENDORID: csr_rdata_s = '0;
         CSR_MARCHID:   csr_rdata_s = '0;
         CSR_MCYCLE: begin
            if (HAS_COUNTERS != 0) csr_rdata_s = cycle_s[DATA_WIDTH-1:0];
            else csr_exists_s = 1'b0;
         end
         CSR_MCYCLEH: begin
            if ((HAS_COUNTERS != 0) && (DATA_WIDTH == 32)) csr_rdata_s = DATA_WIDTH'(cycle_s[63:32]);
            else csr_exists_s = 1'b0;
         end
         default: csr_exists_s = 1'b0;
      endcase
   end

   // Read-modify-write value for the CSR instructions
   always_comb begin
      case (op_s)
         OP_CSRRW: wval_s = req_wdata;
         OP_CSRRS: wval_s = csr_rdata_s | req_wdata;
         OP_CSRRC: wval_s = csr_rdata_s & ~req_wdata;
         default:  wval_s = csr_rdata_s;
      endcase
   end

   // Transaction FSM, CSR commit and registered response
   always_comb begin
      state_d        = state_q;
      mie_d          = mie_q;
      mpie_d         = mpie_q;
      mtie_d         = mtie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_illegal_d  = rsp_illegal_q;
      rsp_redirect_d = rsp_redirect_q;
      rsp_target_d   = rsp_target_q;
      cyc_wr_lo_s    = 1'b0;
      cyc_wr_hi_s    = 1'b0;
      if (accept_s) begin
         state_d        = S_RESP;
         rsp_valid_d    = 1'b1;
         rsp_rdata_d    = '0;
         rsp_illegal_d  = 1'b0;
         rsp_redirect_d = 1'b0;
         rsp_target_d   = '0;
         if (irq_take_s) begin
            mepc_d         = DATA_WIDTH'(req_pc) & EPC_MASK;
            mcause_d       = {1'b1, (DATA_WIDTH-1)'(CAUSE_IRQ_MTI)};
            mpie_d         = mie_q;
            mie_d          = 1'b0;
            rsp_redirect_d = 1'b1;
            rsp_target_d   = trap_tgt_s;
         end else begin
            case (op_s)
               OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                  if (illegal_s) begin
                     rsp_illegal_d = 1'b1;
                  end else begin
                     rsp_rdata_d = csr_rdata_s;
                     if (wr_s) begin
                        case (req_addr)
                           CSR_MSTATUS: begin
                              mie_d  = wval_s[MSTATUS_MIE];
                              mpie_d = wval_s[MSTATUS_MPIE];
                           end
                           CSR_MIE:     mtie_d   = wval_s[MIE_MTIE];
                           CSR_MTVEC:   mtvec_d  = wval_s;
                           CSR_MEPC:    mepc_d   = wval_s & EPC_MASK;
                           CSR_MCAUSE:  mcause_d = wval_s;
                           CSR_MCYCLE: begin
                              cyc_wr_lo_s = 1'b1;
                              cyc_wr_hi_s = (DATA_WIDTH == 64);
                           end
                           CSR_MCYCLEH: cyc_wr_hi_s = 1'b1;
                           default:     cyc_wr_lo_s = 1'b0;
                        endcase
                     end else begin
                        cyc_wr_lo_s = 1'b0;
                     end
                  end
               end
               OP_ECALL: begin
                  mepc_d         = DATA_WIDTH'(req_pc) & EPC_MASK;
                  mcause_d       = DATA_WIDTH'(CAUSE_ECALL_M);
                  mpie_d         = mie_q;
                  mie_d          = 1'b0;
                  rsp_redirect_d = 1'b1;
                  rsp_target_d   = trap_tgt_s;
               end
               OP_MRET: begin
                  mie_d          = mpie_q;
                  mpie_d         = 1'b1;
                  rsp_redirect_d = 1'b1;
                  rsp_target_d   = ADDR_WIDTH'(mepc_q);
               end
               default: rsp_rdata_d = '0;
            endcase
         end
      end else if ((state_q == S_RESP) && rsp_ready) begin
         state_d        = S_IDLE;
         rsp_valid_d    = 1'b0;
         rsp_rdata_d    = '0;
         rsp_illegal_d  = 1'b0;
         rsp_redirect_d = 1'b0;
         rsp_target_d   = '0;
      end else begin
         state_d = state_q;
      end
   end

   // State and CSR registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         mie_q          <= MSTATUS_RST[MSTATUS_MIE];
         mpie_q         <= MSTATUS_RST[MSTATUS_MPIE];
         mtie_q         <= 1'b0;
         mtvec_q        <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_illegal_q  <= 1'b0;
         rsp_redirect_q <= 1'b0;
         rsp_target_q   <= '0;
      end else begin
         state_q        <= state_d;
         mie_q          <= mie_d;
         mpie_q         <= mpie_d;
         mtie_q         <= mtie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_illegal_q  <= rsp_illegal_d;
         rsp_redirect_q <= rsp_redirect_d;
         rsp_target_q   <= rsp_target_d;
      end
   end

   generate
      if (HAS_COUNTERS != 0) begin : g_cnt
         csr_counter u_cnt (
            .clk_i      (clk),
            .rst_ni     (rst),
            .wr_lo_i    (cyc_wr_lo_s),
            .wr_hi_i    (cyc_wr_hi_s),
            .wdata_lo_i (wval_s[31:0]),
            .wdata_hi_i (wval_s[DATA_WIDTH-1:DATA_WIDTH-32]),
            .count_o    (cycle_s)
         );
      end else begin : g_nocnt
         assign cycle_s = 64'd0;
      end
   endgenerate

   assign req_ready    = (state_q == S_IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_illegal  = rsp_illegal_q;
   assign rsp_redirect = rsp_redirect_q;
   assign rsp_target   = rsp_target_q;

endmodule
